// File: rtl/latch_arb_pkg.sv
// Shared types for the latch write arbiter.
//   state_t  : write-sequencer states (IDLE, SETUP, ENABLE, HOLD)
//   req_id_t : requester identity (REQ_CPU, REQ_DSP)
//   ENW_MAX  : largest supported latch-enable width in cycles
package latch_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DSP = 1'b1
  } req_id_t;

  localparam int ENW_MAX = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst   : clock, asynchronous active-high reset
//   cpu_req    : CPU request level
//   dsp_req    : DSP request level
//   ack        : high in the cycle a write is acknowledged
//   ack_id     : requester being acknowledged
//   gnt_valid  : at least one request is present
//   gnt_id     : requester that wins if a grant is taken this cycle
// The last-grant pointer moves on ACK. During the ACK cycle the pointer
// update is forwarded so a grant taken in that same cycle already sees the
// requester just served as "last".
module rr_arb2
  import latch_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    cpu_req,
  input  logic    dsp_req,
  input  logic    ack,
  input  req_id_t ack_id,
  output logic    gnt_valid,
  output req_id_t gnt_id
);

  req_id_t last_q;
  req_id_t eff_last;

  // Reset to "DSP last" so the CPU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_DSP;
    end else if (ack) begin
      last_q <= ack_id;
    end
  end

  always_comb begin
    eff_last  = ack ? ack_id : last_q;
    gnt_valid = cpu_req | dsp_req;
    gnt_id    = REQ_CPU;
    if (cpu_req && dsp_req) begin
      gnt_id = (eff_last == REQ_CPU) ? REQ_DSP : REQ_CPU;
    end else if (dsp_req) begin
      gnt_id = REQ_DSP;
    end
  end

endmodule

// File: rtl/latch_wr_arb.sv
// Arbitrates CPU and DSP writes onto a bank of transparent latches.
//   CLK, RESET          : clock, asynchronous active-high reset
//   CPU_REQ/ADDR/DATA   : CPU write request, register index, data
//   DSP_REQ/ADDR/DATA   : DSP write request, register index, data
//   CPU_ACK, DSP_ACK    : one-cycle write-completion pulses
//   LD                  : data bus shared by all latch D inputs
//   EB                  : one-hot latch enables (bit i -> register i)
//   BUSY                : sequencer not in IDLE
//   ADDR_ERR            : pulses with the ACK when the address is >= NREG
//   DBG_STATE           : current sequencer state
// Handshake: a requester raises REQ with ADDR/DATA stable and holds it until
// its ACK pulse; ACK high for one cycle means the write is complete. A REQ
// still high on the edge ending the ACK cycle is taken as a new request.
// Write sequence: SETUP (data on LD, EB low), ENABLE for ENW cycles
// (EB[addr] high), HOLD (EB low, ACK pulse). EB and ACKs come straight from
// flops so the latch enables never glitch.
module latch_wr_arb
  import latch_arb_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int ENW  = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            CPU_REQ,
  input  logic [2:0]      CPU_ADDR,
  input  logic [DW-1:0]   CPU_DATA,
  input  logic            DSP_REQ,
  input  logic [2:0]      DSP_ADDR,
  input  logic [DW-1:0]   DSP_DATA,
  output logic            CPU_ACK,
  output logic            DSP_ACK,
  output logic [DW-1:0]   LD,
  output logic [NREG-1:0] EB,
  output logic            BUSY,
  output logic            ADDR_ERR,
  output logic [1:0]      DBG_STATE
);

  localparam int ENW_C = (ENW < 1) ? 1 : ((ENW > ENW_MAX) ? ENW_MAX : ENW);
  localparam logic [1:0] ENW_LOAD = 2'(ENW_C - 1);
  localparam logic [3:0] NREG_L   = 4'(NREG);

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [2:0]      addr_q;
  logic [DW-1:0]   data_q;
  req_id_t         owner_q;
  logic [NREG-1:0] eb_q;
  logic            cpu_ack_q, dsp_ack_q, addr_err_q;

  logic            gnt_valid;
  req_id_t         gnt_id;
  logic            take;
  logic            addr_ok;
  logic [NREG-1:0] onehot;

  rr_arb2 u_arb (
    .clk       (CLK),
    .rst       (RESET),
    .cpu_req   (CPU_REQ),
    .dsp_req   (DSP_REQ),
    .ack       (state_q == HOLD),
    .ack_id    (owner_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign addr_ok = ({1'b0, addr_q} < NREG_L);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      onehot[i] = (addr_q == 3'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = SETUP;
          take    = 1'b1;
        end
      end
      SETUP: begin
        state_d = ENABLE;
        cnt_d   = ENW_LOAD;
      end
      ENABLE: begin
        if (cnt_q == 2'd0) state_d = HOLD;
        else               cnt_d   = cnt_q - 2'd1;
      end
      HOLD: begin
        if (gnt_valid) begin
          state_d = SETUP;
          take    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      addr_q     <= 3'd0;
      data_q     <= '0;
      owner_q    <= REQ_CPU;
      eb_q       <= '0;
      cpu_ack_q  <= 1'b0;
      dsp_ack_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        owner_q <= gnt_id;
        addr_q  <= (gnt_id == REQ_CPU) ? CPU_ADDR : DSP_ADDR;
        data_q  <= (gnt_id == REQ_CPU) ? CPU_DATA : DSP_DATA;
      end
      // Registered from next state so the outputs line up with the state.
      eb_q       <= (state_d == ENABLE && addr_ok) ? onehot : '0;
      cpu_ack_q  <= (state_d == HOLD) && (owner_q == REQ_CPU);
      dsp_ack_q  <= (state_d == HOLD) && (owner_q == REQ_DSP);
      addr_err_q <= (state_d == HOLD) && !addr_ok;
    end
  end

  assign LD        = data_q;
  assign EB        = eb_q;
  assign CPU_ACK   = cpu_ack_q;
  assign DSP_ACK   = dsp_ack_q;
  assign ADDR_ERR  = addr_err_q;
  assign BUSY      = (state_q != IDLE);
  assign DBG_STATE = state_q;

endmodule
